// File: rtl/mem_arbiter.sv
// Two-port (CPU priority, DMA with starvation guard) arbiter in front of a single-ported,
// fixed-latency data SRAM. One access in flight at a time: IDLE -> BUSY (MEM_LAT cycles) -> RESP.

// Per-requester response side: read-data capture and the one-cycle ack.
module mem_arb_port #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic                  we,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  ack,
  output logic [WORD_WIDTH-1:0] rdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= done;
      // writes leave the last read value visible to the requester
      if (done && !we) rdata <= mem_rdata;
    end
  end

endmodule

module mem_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [WORD_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  dma_read,
  input  logic                  dma_write,
  input  logic [WORD_WIDTH-1:0] dma_addr,
  input  logic [WORD_WIDTH-1:0] dma_wdata,
  output logic [WORD_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam int NUM_PORTS = 2;
  localparam int CPU = 0;
  localparam int DMA = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic                  we;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
  } cmd_t;

  state_t state, state_nx;
  cmd_t   cmd;
  logic   owner;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       grant, grant_dma;

  logic [NUM_PORTS-1:0]                 req, port_we, done, ack;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0] port_addr, port_wdata, port_rdata;

  // both strobes high is treated as a write
  assign req        = {dma_read | dma_write, cpu_read | cpu_write};
  assign port_we    = {dma_write, cpu_write};
  assign port_addr  = {dma_addr, cpu_addr};
  assign port_wdata = {dma_wdata, cpu_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_dma = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant     = 1'b1;
        grant_dma = req[DMA] & (~req[CPU] | (starve_cnt == 4'(STARVE_LIMIT)));
        state_nx  = BUSY;
      end
      BUSY: if (lat_cnt == 4'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      cmd     <= '0;
      lat_cnt <= 4'd0;
    end else if (grant) begin
      owner   <= grant_dma;
      cmd.we  <= grant_dma ? port_we[DMA]    : port_we[CPU];
      cmd.addr  <= grant_dma ? port_addr[DMA]  : port_addr[CPU];
      cmd.wdata <= grant_dma ? port_wdata[DMA] : port_wdata[CPU];
      lat_cnt <= 4'(MEM_LAT);
    end else if (state == BUSY) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Counts CPU wins while the DMA waits; a full count hands the next slot to the DMA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!req[DMA] || grant_dma)
        starve_cnt <= 4'd0;
      else if (grant && starve_cnt != 4'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_PORTS; i++) begin : g_port
      assign done[i] = (state == BUSY) && (lat_cnt == 4'd1) && (owner == 1'(i));
      mem_arb_port #(.WORD_WIDTH(WORD_WIDTH)) u_port (
        .clk       (clk),
        .rst       (rst),
        .done      (done[i]),
        .we        (cmd.we),
        .mem_rdata (mem_rdata),
        .ack       (ack[i]),
        .rdata     (port_rdata[i])
      );
    end
  endgenerate

  assign cpu_ack   = ack[CPU];
  assign dma_ack   = ack[DMA];
  assign cpu_rdata = port_rdata[CPU];
  assign dma_rdata = port_rdata[DMA];
  assign cpu_stall = (cpu_read | cpu_write) & ~cpu_ack;

  // strobes decode straight from state so an async reset drops them at once
  assign mem_read  = (state == BUSY) & ~cmd.we;
  assign mem_write = (state == BUSY) &  cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven single accesses with a per-port rdata scoreboard,
// plus hand sequences for contention, starvation, reset-in-flight and MEM_LAT=1 throughput.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        cpu_read, cpu_write, dma_read, dma_write;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_read, mem_write;

  logic        b_cpu_read;
  logic [31:0] b_cpu_addr;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_read, b_mem_write;
  logic        zero1;
  logic [31:0] zero32;

  int checks = 0;
  int fails  = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] sram[0:63];

  mem_arbiter #(.WORD_WIDTH(32), .MEM_LAT(2), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WORD_WIDTH(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst(rst),
    .cpu_read(b_cpu_read), .cpu_write(zero1), .cpu_addr(b_cpu_addr), .cpu_wdata(zero32),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_stall(b_cpu_stall),
    .dma_read(zero1), .dma_write(zero1), .dma_addr(zero32), .dma_wdata(zero32),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for u_a: preloaded on reset, written by the arbiter's strobes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram[i] <= (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
    end else if (mem_write) begin
      sram[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata   = mem_read ? sram[mem_addr[7:2]] : 32'h0;
  assign b_mem_rdata = b_mem_read ? (32'h0B0B_0000 | b_mem_addr) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every ack pops the expected rdata for that port
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_spurious_ack", 32'(cpu_ack), 32'd0);
        else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (dma_ack) begin
        if (dma_q.size() == 0) chk("dma_spurious_ack", 32'(dma_ack), 32'd0);
        else chk("dma_rdata", dma_rdata, dma_q.pop_front());
      end
    end
  end

  typedef struct {
    bit          dma;
    bit          rd;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic txn(input vec_t v);
    int n;
    bit got;
    @(posedge clk); #1;
    if (v.dma) begin
      dma_read = v.rd; dma_write = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
      dma_q.push_back(v.exp_rdata);
    end else begin
      cpu_read = v.rd; cpu_write = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      cpu_q.push_back(v.exp_rdata);
    end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = v.dma ? dma_ack : cpu_ack;
      if (!got) begin
        chk("strobes", {30'b0, mem_read, mem_write}, (n == 0) ? 32'd0 : (v.we ? 32'd1 : 32'd2));
        if (n > 0) chk("mem_addr", mem_addr, v.addr);
        if (n > 0 && v.we) chk("mem_wdata", mem_wdata, v.wdata);
        if (!v.dma) chk("cpu_stall_wait", 32'(cpu_stall), 32'd1);
        n++;
      end
    end
    chk("ack_latency", 32'(n), 32'(v.exp_lat));
    if (got) begin
      chk("resp_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      if (!v.dma) chk("cpu_stall_ack", 32'(cpu_stall), 32'd0);
    end
    @(posedge clk); #1;
    if (v.dma) begin dma_read = 0; dma_write = 0; end
    else begin cpu_read = 0; cpu_write = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   cyc[6];
    bit   own[6];
    int   k, c_ack, d_ack;
    bit   drop_c, drop_d;

    tbl[0] = '{0, 1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 3};
    tbl[1] = '{0, 0, 1, 32'h24, 32'h12345678, 32'hDEADBEEF, 3};
    tbl[2] = '{0, 1, 0, 32'h24, 32'h0,        32'h12345678, 3};
    tbl[3] = '{1, 1, 0, 32'h08, 32'h0,        32'h10000002, 3};
    tbl[4] = '{1, 0, 1, 32'h30, 32'hCAFEF00D, 32'h10000002, 3};
    tbl[5] = '{1, 1, 0, 32'h30, 32'h0,        32'hCAFEF00D, 3};
    tbl[6] = '{0, 1, 0, 32'h30, 32'h0,        32'hCAFEF00D, 3};
    tbl[7] = '{0, 1, 1, 32'h3C, 32'h55AA55AA, 32'hCAFEF00D, 3};
    tbl[8] = '{1, 1, 0, 32'h3C, 32'h0,        32'h55AA55AA, 3};

    rst = 1; zero1 = 0; zero32 = 0;
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_read = 0; dma_write = 0; dma_addr = 0; dma_wdata = 0;
    b_cpu_read = 0; b_cpu_addr = 0;

    repeat (2) @(negedge clk);
    chk("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'b0, cpu_ack, dma_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    rst = 0;

    foreach (tbl[i]) txn(tbl[i]);

    // simultaneous requests: CPU first, DMA afterwards
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 32'h10; dma_read = 1; dma_addr = 32'h08;
    cpu_q.push_back(32'hDEADBEEF); dma_q.push_back(32'h10000002);
    c_ack = -1; d_ack = -1;
    for (int n = 0; n < 12 && d_ack < 0; n++) begin
      @(negedge clk);
      if (n == 1) chk("starve_one", 32'(u_a.starve_cnt), 32'd1);
      drop_c = cpu_ack; drop_d = dma_ack;
      if (cpu_ack && c_ack < 0) c_ack = n;
      if (dma_ack && d_ack < 0) d_ack = n;
      @(posedge clk); #1;
      if (drop_c) cpu_read = 0;
      if (drop_d) dma_read = 0;
    end
    chk("contend_cpu_ack_cyc", 32'(c_ack), 32'd3);
    chk("contend_dma_ack_cyc", 32'(d_ack), 32'd7);
    cpu_read = 0; dma_read = 0;

    // starvation guard: CPU held, DMA pending -> 4 CPU grants then DMA
    @(posedge clk); #1;
    cpu_read = 1; cpu_addr = 32'h10; dma_read = 1; dma_addr = 32'h08;
    repeat (5) cpu_q.push_back(32'hDEADBEEF);
    dma_q.push_back(32'h10000002);
    for (int j = 0; j < 6; j++) begin cyc[j] = -1; own[j] = 0; end
    k = 0;
    for (int n = 0; n < 30 && k < 6; n++) begin
      @(negedge clk);
      if (n == 13) chk("starve_saturated", 32'(u_a.starve_cnt), 32'd4);
      if (n == 17) chk("starve_cleared", 32'(u_a.starve_cnt), 32'd0);
      drop_d = dma_ack;
      if (cpu_ack && k < 6) begin cyc[k] = n; own[k] = 0; k++; end
      if (dma_ack && k < 6) begin cyc[k] = n; own[k] = 1; k++; end
      @(posedge clk); #1;
      if (drop_d) dma_read = 0;
    end
    cpu_read = 0; dma_read = 0;
    for (int j = 0; j < 6; j++) begin
      chk("starve_ack_cyc", 32'(cyc[j]), 32'(3 + 4 * j));
      chk("starve_ack_owner", 32'(own[j]), (j == 4) ? 32'd1 : 32'd0);
    end

    // reset during the first BUSY cycle of a write
    @(posedge clk); #1;
    cpu_write = 1; cpu_addr = 32'h20; cpu_wdata = 32'h77;
    @(posedge clk); #1;
    chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
    #2 rst = 1;
    #1;
    chk("rst_busy_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_busy_addr", mem_addr, 32'd0);
    chk("rst_busy_state", 32'(u_a.state), 32'd0);
    chk("rst_busy_acks", {30'b0, cpu_ack, dma_ack}, 32'd0);
    chk("rst_busy_rdata", cpu_rdata | dma_rdata, 32'd0);
    cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    @(negedge clk); rst = 0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack || dma_ack || mem_write || mem_read) k++;
    end
    chk("no_ack_after_rst", 32'(k), 32'd0);

    // MEM_LAT=1 instance: CPU held -> ack every 3 cycles, no starvation count
    @(posedge clk); #1;
    b_cpu_read = 1; b_cpu_addr = 32'h44;
    k = 0;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      if (b_cpu_ack) begin
        chk("lat1_ack_cyc", 32'(n), 32'(2 + 3 * k));
        chk("lat1_rdata", b_cpu_rdata, 32'h0B0B0044);
        chk("lat1_starve", 32'(u_b.starve_cnt), 32'd0);
        k++;
      end
    end
    chk("lat1_ack_count", 32'(k), 32'd4);
    b_cpu_read = 0;

    repeat (3) @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dma_q_drained", 32'(dma_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
